// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Sequential restoring divider. Divides a DW-bit dividend by
//                a VW-bit divisor and produces one quotient bit per clock.
//                Uses a start/done handshake. A zero divisor completes
//                immediately with a saturated quotient and the div_zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    // The iteration counter must be able to hold the value DW.
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] C_COUNT_INIT = CW'(DW);
    localparam logic [CW-1:0] C_COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Working registers. The quotient accumulator keeps only DW-1 bits
    // because the final bit comes straight from the last trial subtract.
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_rem_work;
    logic [DW-2:0] r_quo_work;
    logic [CW-1:0] r_count;

    logic          w_load;
    logic          w_zero_div;
    logic          w_last;
    logic [VW:0]   w_trial;
    logic [VW:0]   w_diff;
    logic          w_ge;
    logic [VW-1:0] w_rem_next;
    logic [DW-1:0] w_quo_next;

    assign w_last = (r_count == C_COUNT_ONE);

    // Trial subtract for one iteration. Because the partial remainder is
    // always below the divisor, T - V fits in VW+1 bits as a signed value,
    // so its top bit is the borrow and tells whether T >= V.
    assign w_trial    = {r_rem_work, r_dvd[DW-1]};
    assign w_diff     = w_trial - {1'b0, r_dvs};
    assign w_ge       = ~w_diff[VW];
    assign w_rem_next = w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
    assign w_quo_next = {r_quo_work, w_ge};

    assign busy = (r_state == ST_CALC);
    assign done = (r_state == ST_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the accept strobes for normal and zero-divisor ops.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_zero_div  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        w_state_nxt = ST_DONE;
                        w_zero_div  = 1'b1;
                    end else begin
                        w_state_nxt = ST_CALC;
                        w_load      = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working datapath: capture operands on accept, then shift and subtract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem_work <= '0;
            r_quo_work <= '0;
            r_count    <= '0;
        end else if (w_load) begin
            r_dvd      <= dividend;
            r_dvs      <= divisor;
            r_rem_work <= '0;
            r_quo_work <= '0;
            r_count    <= C_COUNT_INIT;
        end else if (r_state == ST_CALC) begin
            r_dvd      <= {r_dvd[DW-2:0], 1'b0};
            r_rem_work <= w_rem_next;
            r_quo_work <= w_quo_next[DW-2:0];
            r_count    <= r_count - C_COUNT_ONE;
        end
    end

    // Result registers: updated only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (w_zero_div) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
        end else if ((r_state == ST_CALC) && w_last) begin
            quotient  <= w_quo_next;
            remainder <= w_rem_next;
            div_zero  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Self-checking bench for seq_restoring_divider with directed
//                vectors, reset abort, zero divisor and back-to-back ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       div_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    seq_restoring_divider #(.DW(6), .VW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter for spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one operation from a posedge+1 point in IDLE or DONE and wait
    // for done. Operands are scrambled after acceptance. Returns the number
    // of edges after the accepting edge until done, busy samples, whether
    // the results moved before done, and whether the wait timed out.
    task automatic do_op(input logic [5:0] a, input logic [2:0] b,
                         output int lat, output int busy_cnt,
                         output logic [5:0] q, output logic [2:0] r,
                         output logic dz, output bit changed,
                         output bit timed_out);
        logic [5:0] q0;
        logic [2:0] r0;
        q0 = quotient;
        r0 = remainder;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 6'($urandom);
        divisor  = 3'($urandom);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        changed  = 1'b0;
        while (!done && lat < 20) begin
            if (quotient !== q0 || remainder !== r0) changed = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
        timed_out = !done;
        q  = quotient;
        r  = remainder;
        dz = div_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (quotient !== 6'd0) begin n_fail++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
        n_tests++; if (remainder !== 3'd0) begin n_fail++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_basic();
        int lat, bc; logic [5:0] q; logic [2:0] r; logic dz; bit ch, to;
        do_op(6'd42, 3'd7, lat, bc, q, r, dz, ch, to);
        n_tests++; if (to || lat != 6) begin n_fail++; $display("FAIL basic_latency got=%0d exp=6", lat); end
        n_tests++; if (bc != 6) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=6", bc); end
        n_tests++; if (q !== 6'd6) begin n_fail++; $display("FAIL basic_quotient got=%0d exp=6", q); end
        n_tests++; if (r !== 3'd0) begin n_fail++; $display("FAIL basic_remainder got=%0d exp=0", r); end
        n_tests++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_div_zero got=%b exp=0", dz); end
        n_tests++; if (ch) begin n_fail++; $display("FAIL basic_hold_during_calc got=1 exp=0"); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse_width got=%b exp=0", done); end
        n_tests++; if (quotient !== 6'd6 || remainder !== 3'd0) begin n_fail++; $display("FAIL basic_result_hold got=%0d/%0d exp=6/0", quotient, remainder); end
    endtask

    task automatic test_patterns();
        int lat, bc; logic [5:0] q; logic [2:0] r; logic dz; bit ch, to;
        logic [5:0] va [5] = '{6'd49, 6'd5, 6'd63, 6'd62, 6'd13};
        logic [2:0] vb [5] = '{3'd3, 3'd7, 3'd1, 3'd5, 3'd4};
        logic [5:0] vq [5] = '{6'd16, 6'd0, 6'd63, 6'd12, 6'd3};
        logic [2:0] vr [5] = '{3'd1, 3'd5, 3'd0, 3'd2, 3'd1};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], lat, bc, q, r, dz, ch, to);
            n_tests++;
            if (to || q !== vq[i] || r !== vr[i] || dz !== 1'b0) begin
                n_fail++;
                $display("FAIL pattern_%0d %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=0",
                         i, va[i], vb[i], q, r, dz, vq[i], vr[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [5:0] q; logic [2:0] r; logic dz; bit ch, to;
        do_op(6'd20, 3'd0, lat, bc, q, r, dz, ch, to);
        n_tests++; if (to || lat != 0) begin n_fail++; $display("FAIL div0_latency got=%0d exp=0 edges after accept", lat); end
        n_tests++; if (bc != 0) begin n_fail++; $display("FAIL div0_busy got=%0d exp=0", bc); end
        n_tests++; if (q !== 6'd63 || r !== 3'd0) begin n_fail++; $display("FAIL div0_result got=%0d/%0d exp=63/0", q, r); end
        n_tests++; if (dz !== 1'b1) begin n_fail++; $display("FAIL div0_flag got=%b exp=1", dz); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0 || div_zero !== 1'b1) begin n_fail++; $display("FAIL div0_hold done=%b dz=%b exp 0/1", done, div_zero); end
        do_op(6'd42, 3'd7, lat, bc, q, r, dz, ch, to);
        n_tests++; if (to || dz !== 1'b0 || q !== 6'd6) begin n_fail++; $display("FAIL div0_clear got dz=%b q=%0d exp dz=0 q=6", dz, q); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat, bc; logic [5:0] q; logic [2:0] r; logic dz; bit ch, to;
        bit saw_done;
        start = 1'b1; dividend = 6'd42; divisor = 3'd7;
        @(posedge clk); #1;                       // E0: accepted
        start = 1'b0;
        @(posedge clk); #1;                       // E1
        start = 1'b1; dividend = 6'd9; divisor = 3'd2;
        @(posedge clk); #1;                       // E2
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_e2 got=%b exp=1", busy); end
        @(posedge clk); #1;                       // E3
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL abort_busy_e3 busy=%b done=%b exp 1/0", busy, done); end
        rst = 1'b1;
        #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 6'd0 || remainder !== 3'd0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async_reset busy=%b done=%b q=%0d r=%0d dz=%b exp all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (i == 1) rst = 1'b0;
        end
        n_tests++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done got=1 exp=0"); end
        do_op(6'd9, 3'd2, lat, bc, q, r, dz, ch, to);
        n_tests++; if (to || q !== 6'd4 || r !== 3'd1) begin n_fail++; $display("FAIL abort_recover got=%0d/%0d exp=4/1", q, r); end
        @(posedge clk); #1;
    endtask

    task automatic test_roundtrip();
        int lat, bc; logic [5:0] q; logic [2:0] r; logic dz; bit ch, to;
        logic [5:0] prod;
        for (int a = 0; a < 8; a++) begin
            for (int b = 1; b < 8; b++) begin
                prod = 6'(a * b);
                do_op(prod, 3'(b), lat, bc, q, r, dz, ch, to);
                n_tests++;
                if (to || q !== 6'(a) || r !== 3'd0) begin
                    n_fail++;
                    $display("FAIL roundtrip %0d/%0d got q=%0d r=%0d exp q=%0d r=0", prod, b, q, r, a);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic [5:0] q; logic [2:0] r; logic dz; bit ch, to;
        int prev_cyc;
        bit first;
        first = 1'b1;
        prev_cyc = 0;
        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 8; b++) begin
                do_op(6'(a), 3'(b), lat, bc, q, r, dz, ch, to);
                n_tests++;
                if (to || q !== 6'(a / b) || r !== 3'(a % b) || dz !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d",
                             a, b, q, r, dz, a / b, a % b);
                end
                n_tests++;
                if (ch) begin
                    n_fail++;
                    $display("FAIL b2b_stable %0d/%0d results moved before done", a, b);
                end
                if (!first) begin
                    n_tests++;
                    if (cyc - prev_cyc != 7) begin
                        n_fail++;
                        $display("FAIL b2b_spacing %0d/%0d got=%0d exp=7", a, b, cyc - prev_cyc);
                    end
                end
                first = 1'b0;
                prev_cyc = cyc;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_abort();
        test_roundtrip();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
